serv_ram_arbiter: RTL and testbench
===================================

Name: serv_ram_arbiter

Overview:
- Shares the single-port 32x32 byte-writable RAM macro between three requesters: the external host byte port, the SERV data bus and the SERV instruction bus.
- Sits between serv_top, the pad-level host interface and the RAM32 instance.
- Sequences every access as IDLE -> ACCESS -> RESP, drives RAM enable, address, byte write strobes and write data from registers, and returns a one-cycle ack with read data.

Parameters:
ADDR_W, 5, RAM word-address width; RAM depth is 2**ADDR_W words of 32 bits.
HOST_AW, 7, host byte-address width; HOST_AW must equal ADDR_W+2.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
host_req  input  1  host access request, level, held until host_ack
host_we  input  1  host write (1) / read (0)
host_addr  input  HOST_AW  host byte address; [1:0] is the byte lane, [HOST_AW-1:2] is the word
host_wdata  input  8  host write byte
host_rdata  output  8  host read byte, valid while host_ack=1
host_ack  output  1  host completion pulse
ibus_cyc  input  1  SERV instruction request
ibus_adr  input  32  SERV instruction address
ibus_rdt  output  32  instruction read data, valid while ibus_ack=1
ibus_ack  output  1  instruction completion pulse
dbus_cyc  input  1  SERV data request
dbus_adr  input  32  SERV data address
dbus_we  input  1  SERV data write
dbus_wdt  input  32  SERV write data
dbus_sel  input  4  SERV byte selects
dbus_rdt  output  32  data read data, valid while dbus_ack=1
dbus_ack  output  1  data completion pulse
ram_en  output  1  RAM enable
ram_a  output  ADDR_W  RAM word address
ram_we  output  4  RAM byte write strobes
ram_di  output  32  RAM write data
ram_do  input  32  RAM read data, valid the cycle after an enabled edge

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; ram_en=0, ram_we=0, ram_a=0, ram_di=0; all acks=0; grant=none; round-robin pointer=ibus.
- Reset asserted mid-operation aborts at the next edge and no ack is issued. A write strobe already registered was committed at that edge.
- IDLE: if any request is present, register the winner and load the ram_* registers, then go to ACCESS. With no request, ram_en=0 and the state stays IDLE.
- Priority (macro undefined): host > dbus > ibus.
- ACCESS: ram_en=1 for exactly this cycle; the RAM samples at the end of the cycle. Always go to RESP.
- RESP:
  - Assert the granted requester's ack for exactly one cycle.
  - The granted rdt equals ram_do, combinational pass-through.
  - host_rdata = ram_do byte at the registered lane, i.e. bits [8*lane+7 : 8*lane].
  - Go to IDLE.
- Latency: a request that wins in IDLE cycle N gets its ack in cycle N+2. The minimum request-to-request period is 3 cycles.
- Requesters drop or renew their request after sampling ack. A request seen in IDLE is always treated as a new access.
- ram_a mapping:
  - dbus/ibus: adr[ADDR_W+1:2]; upper address bits are ignored, so addresses alias.
  - host: host_addr[HOST_AW-1:2].
- ram_we:
  - dbus write: dbus_sel.
  - dbus read: 0.
  - ibus: always 0.
  - host write: one-hot (1 << host_addr[1:0]).
  - host read: 0.
- ram_di:
  - dbus: dbus_wdt.
  - host: host_wdata replicated in all 4 lanes.
  - ibus: 0.
- Write accesses also pulse ack in RESP. The rdt contents on a write are don't-care.
- Request inputs are sampled only in IDLE. Changes during ACCESS or RESP are ignored.
- Non-granted acks stay 0, and the rdt outputs of non-granted requesters are don't-care.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Host keeps absolute priority.
  - dbus and ibus alternate by pointer; the pointer flips to the other CPU bus after each CPU grant.
  - A single CPU requester always wins regardless of the pointer.
- Undefined: fixed priority dbus > ibus, and the pointer is absent.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all requests high -> ram_en=0, all acks 0; after release, the first grant goes to host.
- Host write then read:
  - host_addr=7'h05, wdata=8'hA5, we=1 -> ram_a=1, ram_we=4'b0010, ram_di=32'hA5A5A5A5, ack at N+2.
  - Read of addr 7'h05 with ram_do=32'h0000A500 -> host_rdata=8'hA5.
- dbus word write: adr=32'h0000_0010, sel=4'hF, wdt=32'hDEADBEEF -> ram_a=4, ram_we=4'hF, dbus_ack one cycle at N+2.
- Aliasing: ibus_adr=32'h0000_0084 -> ram_a=1, ram_we=0; ibus_rdt equals ram_do in RESP.
- Contention with ibus+dbus+host all held continuously:
  - Macro undefined -> grant order host, host, ...; after host drops, dbus, dbus, ...
  - Macro defined, host idle -> order dbus, ibus, dbus, ibus.
- Mid-access reset: assert rst_n=0 during ACCESS of a dbus read -> no dbus_ack; state IDLE; ram_en=0 the next cycle.

Source files
------------

// File: rtl/serv_ram_arbiter.sv
// serv_ram_arbiter: shares one single-port 32-bit byte-writable RAM between
// the host byte port, the SERV data bus and the SERV instruction bus.
// Every access walks IDLE -> ACCESS -> RESP; RAM controls are registered and
// the winner gets a one-cycle ack in RESP with ram_do passed straight through.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate dbus/ibus grants
// (host keeps absolute priority). Default build is fixed host > dbus > ibus.
// HOST_AW must equal ADDR_W+2 (byte lane in host_addr[1:0]).
module serv_ram_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int HOST_AW = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [HOST_AW-1:0] host_addr,
  input  logic [7:0]         host_wdata,
  output logic [7:0]         host_rdata,
  output logic               host_ack,
  input  logic               ibus_cyc,
  input  logic [31:0]        ibus_adr,
  output logic [31:0]        ibus_rdt,
  output logic               ibus_ack,
  input  logic               dbus_cyc,
  input  logic [31:0]        dbus_adr,
  input  logic               dbus_we,
  input  logic [31:0]        dbus_wdt,
  input  logic [3:0]         dbus_sel,
  output logic [31:0]        dbus_rdt,
  output logic               dbus_ack,
  output logic               ram_en,
  output logic [ADDR_W-1:0]  ram_a,
  output logic [3:0]         ram_we,
  output logic [31:0]        ram_di,
  input  logic [31:0]        ram_do
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_HOST, G_DBUS, G_IBUS} gnt_t;

  state_t     state;
  gnt_t       gnt;
  gnt_t       win;
  logic [1:0] lane;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which CPU bus was served last; the other one wins a tie.
  logic       rr_last_ibus;
`endif

  // Only word-address bits reach the RAM; the rest alias.
  logic unused_adr;
  assign unused_adr = ^{dbus_adr[31:ADDR_W+2], dbus_adr[1:0],
                        ibus_adr[31:ADDR_W+2], ibus_adr[1:0]};

  // Pick the winner among currently presented requests.
  always_comb begin
    win = G_NONE;
    if (host_req)
      win = G_HOST;
    else if (dbus_cyc && ibus_cyc) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = rr_last_ibus ? G_DBUS : G_IBUS;
`else
      win = G_DBUS;
`endif
    end
    else if (dbus_cyc)
      win = G_DBUS;
    else if (ibus_cyc)
      win = G_IBUS;
  end

  // Access sequencer: registers winner and RAM controls, then acks in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= G_NONE;
      lane     <= 2'd0;
      ram_en   <= 1'b0;
      ram_a    <= '0;
      ram_we   <= 4'b0000;
      ram_di   <= 32'h0;
      host_ack <= 1'b0;
      dbus_ack <= 1'b0;
      ibus_ack <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_ibus <= 1'b1;
`endif
    end else begin
      host_ack <= 1'b0;
      dbus_ack <= 1'b0;
      ibus_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          ram_en <= 1'b0;
          ram_we <= 4'b0000;
          if (win != G_NONE) begin
            gnt    <= win;
            ram_en <= 1'b1;
            state  <= S_ACCESS;
            case (win)
              G_HOST: begin
                ram_a  <= host_addr[HOST_AW-1:2];
                ram_we <= host_we ? (4'b0001 << host_addr[1:0]) : 4'b0000;
                ram_di <= {4{host_wdata}};
                lane   <= host_addr[1:0];
              end
              G_DBUS: begin
                ram_a  <= dbus_adr[ADDR_W+1:2];
                ram_we <= dbus_we ? dbus_sel : 4'b0000;
                ram_di <= dbus_wdt;
`ifdef ARB_ROUND_ROBIN_EN
                rr_last_ibus <= 1'b0;
`endif
              end
              default: begin
                ram_a  <= ibus_adr[ADDR_W+1:2];
                ram_we <= 4'b0000;
                ram_di <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
                rr_last_ibus <= 1'b1;
`endif
              end
            endcase
          end
        end
        S_ACCESS: begin
          // RAM samples at this edge; drop enable and raise the ack.
          ram_en   <= 1'b0;
          ram_we   <= 4'b0000;
          state    <= S_RESP;
          host_ack <= (gnt == G_HOST);
          dbus_ack <= (gnt == G_DBUS);
          ibus_ack <= (gnt == G_IBUS);
        end
        S_RESP: begin
          gnt   <= G_NONE;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ibus_rdt = ram_do;
  assign dbus_rdt = ram_do;

  // Host read byte is selected by the lane captured with the request.
  always_comb begin
    case (lane)
      2'd1:    host_rdata = ram_do[15:8];
      2'd2:    host_rdata = ram_do[23:16];
      2'd3:    host_rdata = ram_do[31:24];
      default: host_rdata = ram_do[7:0];
    endcase
  end

endmodule

// File: tb/tb_serv_ram_arbiter.sv
// Bench for serv_ram_arbiter: a behavioural RAM drives ram_do; a
// transaction-level model (shadow memory + priority rule) predicts grants,
// RAM controls and read data. Directed table, contention, mid-access reset,
// then randomized request mixes.
module tb_serv_ram_arbiter;
  localparam int ADDR_W  = 5;
  localparam int HOST_AW = 7;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               host_req, host_we;
  logic [HOST_AW-1:0] host_addr;
  logic [7:0]         host_wdata, host_rdata;
  logic               host_ack;
  logic               ibus_cyc;
  logic [31:0]        ibus_adr, ibus_rdt;
  logic               ibus_ack;
  logic               dbus_cyc, dbus_we;
  logic [31:0]        dbus_adr, dbus_wdt, dbus_rdt;
  logic [3:0]         dbus_sel;
  logic               dbus_ack;
  logic               ram_en;
  logic [ADDR_W-1:0]  ram_a;
  logic [3:0]         ram_we;
  logic [31:0]        ram_di, ram_do;

  always #5 clk = ~clk;

  serv_ram_arbiter #(.ADDR_W(ADDR_W), .HOST_AW(HOST_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
    .dbus_cyc(dbus_cyc), .dbus_adr(dbus_adr), .dbus_we(dbus_we), .dbus_wdt(dbus_wdt),
    .dbus_sel(dbus_sel), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
    .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  // Behavioural single-port RAM: registered read, byte-strobed write.
  logic [31:0] mem [32];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      ram_do <= 32'h0;
    end else if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: requester ids 1=host 2=dbus 3=ibus.
  logic [31:0] smem [32];
  int          last_cpu;
  logic        pend  [4];
  logic        p_we  [4];
  logic [31:0] p_adr [4];
  logic [31:0] p_wd  [4];
  logic [3:0]  p_sel [4];

  typedef struct {
    int          w;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [4:0]  a;
    logic [3:0]  wem;
    logic [31:0] di;
    logic        rdc;
    logic [31:0] rd;
  } vec_t;
  vec_t vt [12];

`ifdef ARB_ROUND_ROBIN_EN
  int cseq [4] = '{2, 3, 2, 3};
`else
  int cseq [3] = '{2, 2, 3};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    host_req   = pend[1];
    host_we    = p_we[1];
    host_addr  = p_adr[1][HOST_AW-1:0];
    host_wdata = p_wd[1][7:0];
    dbus_cyc   = pend[2];
    dbus_we    = p_we[2];
    dbus_adr   = p_adr[2];
    dbus_wdt   = p_wd[2];
    dbus_sel   = p_sel[2];
    ibus_cyc   = pend[3];
    ibus_adr   = p_adr[3];
  endtask

  function automatic logic [4:0] m_a(input int w);
    if (w == 1) return 5'((p_adr[1] % 128) / 4);
    return 5'((p_adr[w] / 4) % 32);
  endfunction

  function automatic logic [3:0] m_we(input int w);
    if (w == 3 || !p_we[w]) return 4'b0000;
    if (w == 1) return 4'(1 << (p_adr[1] % 4));
    return p_sel[2];
  endfunction

  function automatic logic [31:0] m_di(input int w);
    if (w == 1) return 32'(p_wd[1][7:0]) * 32'h0101_0101;
    if (w == 2) return p_wd[2];
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_rd(input int w);
    logic [31:0] word;
    word = smem[m_a(w)];
    if (w == 1) return (word >> (8 * (p_adr[1] % 4))) & 32'hFF;
    return word;
  endfunction

  task automatic m_commit(input int w);
    logic [3:0]  m;
    logic [31:0] d;
    logic [4:0]  a;
    m = m_we(w);
    d = m_di(w);
    a = m_a(w);
    for (int b = 0; b < 4; b++)
      if (m[b]) smem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic int pick();
    if (pend[1]) return 1;
    if (pend[2] && pend[3]) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last_cpu == 3) ? 2 : 3;
`else
      return 2;
`endif
    end
    if (pend[2]) return 2;
    if (pend[3]) return 3;
    return 0;
  endfunction

  // Step until an ack shows up (bounded), recording the enabled RAM cycle.
  task automatic observe(output int who, output int lat, output logic [4:0] a,
                         output logic [3:0] we, output logic [31:0] di,
                         output logic [31:0] rd, output int en_cnt);
    int n;
    who = 0; lat = 0; en_cnt = 0; a = '0; we = '0; di = '0; rd = '0;
    while (who == 0 && lat < 10) begin
      step();
      lat++;
      if (ram_en) begin
        en_cnt++;
        a = ram_a; we = ram_we; di = ram_di;
      end
      n = int'(host_ack) + int'(dbus_ack) + int'(ibus_ack);
      if (n > 1) who = 9;
      else if (host_ack) begin who = 1; rd = {24'h0, host_rdata}; end
      else if (dbus_ack) begin who = 2; rd = dbus_rdt; end
      else if (ibus_ack) begin who = 3; rd = ibus_rdt; end
    end
    chk("ack_seen", 32'(who != 0), 32'd1);
  endtask

  task automatic expect_txn(input string tag, input int w, input int lat_e,
                            input logic [4:0] a_e, input logic [3:0] we_e,
                            input logic [31:0] di_e, input logic rdc,
                            input logic [31:0] rd_e, output int who);
    int lat, en_cnt;
    logic [4:0] a;
    logic [3:0] we;
    logic [31:0] di, rd;
    observe(who, lat, a, we, di, rd, en_cnt);
    chk({tag, "_grant"},   32'(who), 32'(w));
    chk({tag, "_latency"}, 32'(lat), 32'(lat_e));
    chk({tag, "_en_cycles"}, 32'(en_cnt), 32'd1);
    chk({tag, "_ram_a"},   32'(a),  32'(a_e));
    chk({tag, "_ram_we"},  32'(we), 32'(we_e));
    chk({tag, "_ram_di"},  di, di_e);
    if (rdc) chk({tag, "_rdata"}, rd, rd_e);
    if (w > 1) last_cpu = w;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_acks"},   {29'h0, host_ack, dbus_ack, ibus_ack}, 32'h0);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'h0);
  endtask

  initial begin
    int who, w, n_left;
    logic [2:0] mask;

    vt[0]  = '{1, 1'b1, 32'h05,       32'hA5,       4'h0,    5'd1,  4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0};
    vt[1]  = '{1, 1'b0, 32'h05,       32'h00,       4'h0,    5'd1,  4'b0000, 32'h00000000, 1'b1, 32'hA5};
    vt[2]  = '{2, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    5'd4,  4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[3]  = '{2, 1'b0, 32'h10,       32'h12345678, 4'hF,    5'd4,  4'b0000, 32'h12345678, 1'b1, 32'hDEADBEEF};
    vt[4]  = '{3, 1'b0, 32'h84,       32'h0,        4'h0,    5'd1,  4'b0000, 32'h00000000, 1'b1, 32'h0000A500};
    vt[5]  = '{1, 1'b0, 32'h13,       32'h00,       4'h0,    5'd4,  4'b0000, 32'h00000000, 1'b1, 32'hDE};
    vt[6]  = '{2, 1'b1, 32'h0FF4,     32'h11223344, 4'b0101, 5'd29, 4'b0101, 32'h11223344, 1'b0, 32'h0};
    vt[7]  = '{3, 1'b0, 32'h74,       32'h0,        4'h0,    5'd29, 4'b0000, 32'h00000000, 1'b1, 32'h00220044};
    vt[8]  = '{1, 1'b0, 32'h76,       32'h5A,       4'h0,    5'd29, 4'b0000, 32'h5A5A5A5A, 1'b1, 32'h22};
    vt[9]  = '{1, 1'b1, 32'h7F,       32'h3C,       4'h0,    5'd31, 4'b1000, 32'h3C3C3C3C, 1'b0, 32'h0};
    vt[10] = '{2, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h3,    5'd31, 4'b0000, 32'h00000000, 1'b1, 32'h3C000000};
    vt[11] = '{3, 1'b0, 32'hFFFFFF80, 32'h0,        4'h0,    5'd0,  4'b0000, 32'h00000000, 1'b1, 32'h0};

    for (int i = 0; i < 32; i++) smem[i] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      pend[k] = 1'b0; p_we[k] = 1'b0; p_adr[k] = 32'h0; p_wd[k] = 32'h0; p_sel[k] = 4'h0;
    end
    last_cpu = 3;
    mem_clr  = 1'b1;

    // Reset with every requester asserted: nothing may start or ack.
    rst_n = 1'b0;
    for (int k = 1; k < 4; k++) begin
      pend[k] = 1'b1; p_adr[k] = $urandom; p_wd[k] = $urandom;
    end
    drive();
    step();
    step();
    mem_clr = 1'b0;
    chk_idle("reset");
    chk("reset_ram_we", 32'(ram_we), 32'h0);
    chk("reset_ram_a",  32'(ram_a),  32'h0);
    chk("reset_ram_di", ram_di,      32'h0);
    rst_n = 1'b1;

    // Contention, all held: host first and keeps winning while it holds.
    for (int k = 0; k < 3; k++)
      expect_txn("cont_host", 1, (k == 0) ? 2 : 3, m_a(1), 4'h0, m_di(1), 1'b1, m_rd(1), who);
    pend[1] = 1'b0;
    drive();
    foreach (cseq[k]) begin
`ifndef ARB_ROUND_ROBIN_EN
      if (k == 2) begin pend[2] = 1'b0; drive(); end
`endif
      expect_txn("cont_cpu", cseq[k], 3, m_a(cseq[k]), 4'h0, m_di(cseq[k]), 1'b1, m_rd(cseq[k]), who);
    end
    for (int k = 0; k < 4; k++) pend[k] = 1'b0;
    drive();
    step();
    chk_idle("cont_end");

    // Directed vectors, one requester at a time from IDLE.
    for (int i = 0; i < 12; i++) begin
      w = vt[i].w;
      p_we[w] = vt[i].we; p_adr[w] = vt[i].adr; p_wd[w] = vt[i].wd; p_sel[w] = vt[i].sel;
      pend[w] = 1'b1;
      drive();
      expect_txn($sformatf("vec%0d", i), w, 2, vt[i].a, vt[i].wem, vt[i].di, vt[i].rdc, vt[i].rd, who);
      m_commit(w);
      pend[w] = 1'b0;
      drive();
      step();
      chk_idle($sformatf("vec%0d_after", i));
    end

    // Reset while a dbus read is in ACCESS: the access is dropped silently.
    p_we[2] = 1'b0; p_adr[2] = 32'h10; pend[2] = 1'b1;
    drive();
    step();
    chk("midrst_access_en", 32'(ram_en), 32'h1);
    rst_n = 1'b0;
    pend[2] = 1'b0;
    drive();
    step();
    chk("midrst_no_ack", 32'(dbus_ack), 32'h0);
    chk("midrst_ram_en", 32'(ram_en), 32'h0);
    step();
    chk_idle("midrst_hold");
    rst_n = 1'b1;
    last_cpu = 3;
    step();
    chk_idle("midrst_release");

    // Random request mixes; each requester drops once acked.
    for (int it = 0; it < 60; it++) begin
      mask = 3'($urandom_range(1, 7));
      for (int k = 1; k < 4; k++) begin
        pend[k]  = mask[k-1];
        p_we[k]  = 1'($urandom_range(0, 1));
        p_adr[k] = $urandom;
        p_wd[k]  = $urandom;
        p_sel[k] = 4'($urandom_range(0, 15));
      end
      drive();
      n_left = 0;
      while (pick() != 0 && n_left < 3) begin
        w = pick();
        expect_txn("rnd", w, (n_left == 0) ? 2 : 3, m_a(w), m_we(w), m_di(w),
                   (w == 3) || !p_we[w], m_rd(w), who);
        m_commit(w);
        pend[w] = 1'b0;
        if (who >= 1 && who <= 3) pend[who] = 1'b0;
        drive();
        n_left++;
      end
      step();
      chk_idle("rnd_after");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
